// File: rtl/noc_pkg.sv
// Shared NoC switch definitions: default flit width, flit header field offsets
// and the output-port arbiter state encoding.
package noc_pkg;

    localparam int DataWidthDef = 32;

    // Header fields live in the low bits of every flit.
    localparam int FlitDestLsb = 0;
    localparam int FlitDestW   = 4;
    localparam int FlitSrcLsb  = 4;
    localparam int FlitSrcW    = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arbState_t;

endpackage

// File: rtl/noc_port_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr
// (wrapping) wins; returns it as one-hot and as an index.
module rr_pick #(
    parameter int N    = 3,
    parameter int IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grantIdx,
    output logic            any
);

    always_comb begin
        int idx;
        grant    = '0;
        grantIdx = '0;
        any      = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!any && req[idx]) begin
                any         = 1'b1;
                grant[idx]  = 1'b1;
                grantIdx    = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// Burst-limited round-robin arbiter for one switch output link, feeding the
// link through a single registered output stage.
module noc_port_arbiter
    import noc_pkg::*;
#(
    parameter int DataWidth = DataWidthDef,
    parameter int NumReq    = 3,
    parameter int BurstLen  = 4
) (
    input  logic                        i_sclk,
    input  logic                        i_reset,
    input  logic [NumReq*DataWidth-1:0] i_req_data,
    input  logic [NumReq-1:0]           i_req_data_valid,
    output logic [NumReq-1:0]           o_req_data_ready,
    output logic [DataWidth-1:0]        o_data,
    output logic                        o_data_valid,
    input  logic                        i_data_ready,
    output logic [NumReq-1:0]           o_grant,
    output logic                        o_busy
);

    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = $clog2(BurstLen + 1);

    logic [NumReq-1:0][DataWidth-1:0] reqData;
    arbState_t                        state;
    logic [IdxW-1:0]                  ptr;
    logic [IdxW-1:0]                  grantIdx;
    logic [CntW-1:0]                  count;
    logic [NumReq-1:0]                pickOneHot;
    logic [IdxW-1:0]                  pickIdx;
    logic                             pickAny;
    logic                             loadEn;
    logic                             holderValid;
    logic                             xfer;
    logic                             lastFlit;
    logic [IdxW-1:0]                  nextPtr;

    assign reqData     = i_req_data;
    assign loadEn      = !o_data_valid || i_data_ready;
    assign holderValid = i_req_data_valid[grantIdx];
    assign xfer        = (state == ST_GRANT) && holderValid && loadEn;
    assign lastFlit    = (count == CntW'(BurstLen - 1));
    assign nextPtr     = (grantIdx == IdxW'(NumReq - 1)) ? '0 : grantIdx + IdxW'(1);

    // o_grant is zero outside GRANT, so this also gates ready in IDLE.
    assign o_req_data_ready = loadEn ? o_grant : '0;
    assign o_busy           = (state == ST_GRANT) || o_data_valid;

    rr_pick #(
        .N    (NumReq),
        .IdxW (IdxW)
    ) uPick (
        .req      (i_req_data_valid),
        .ptr      (ptr),
        .grant    (pickOneHot),
        .grantIdx (pickIdx),
        .any      (pickAny)
    );

    always_ff @(posedge i_sclk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= ST_IDLE;
            o_grant  <= '0;
            grantIdx <= '0;
            ptr      <= '0;
            count    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pickAny) begin
                        state    <= ST_GRANT;
                        o_grant  <= pickOneHot;
                        grantIdx <= pickIdx;
                        count    <= '0;
                    end
                end
                ST_GRANT: begin
                    // Release on burst end or when the holder goes quiet;
                    // the holder then gets lowest priority.
                    if (!holderValid || (xfer && lastFlit)) begin
                        state   <= ST_IDLE;
                        o_grant <= '0;
                        ptr     <= nextPtr;
                        count   <= '0;
                    end else if (xfer) begin
                        count <= count + CntW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_sclk or negedge i_reset) begin
        if (!i_reset) begin
            o_data       <= '0;
            o_data_valid <= 1'b0;
        end else if (xfer) begin
            o_data       <= reqData[grantIdx];
            o_data_valid <= 1'b1;
        end else if (i_data_ready) begin
            o_data_valid <= 1'b0;
        end
    end

endmodule
